// File: rtl/reduce_accum_stream.sv
// reduce_accum_stream: folds a frame of WIDTH-bit words (one per beat) into a
// column vector using AND / OR / XOR / NAND, then reduces that vector to one bit.
// The result is held on a valid/ready output until downstream takes it.
//
// Ports:
//   CLK, RST               clock, synchronous active-high reset
//   MODE                   operator select, sampled on the first beat of a frame
//   IN_VALID/IN_READY      input handshake; IN_DATA word, IN_LAST ends the frame
//   OUT_VALID/OUT_READY    result handshake
//   OUT_VEC, OUT_BIT       folded column vector and its reduction
//   OUT_CNT, OUT_OVF       words accepted (saturating) and frame-too-long flag
module reduce_accum_stream #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_WORDS = 16,
  localparam int unsigned CNT_W    = $clog2(MAX_WORDS + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       MODE,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_LAST,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_VEC,
  output logic             OUT_BIT,
  output logic [CNT_W-1:0] OUT_CNT,
  output logic             OUT_OVF
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_AND  = 2'b00;
  localparam logic [1:0] MODE_OR   = 2'b01;
  localparam logic [1:0] MODE_XOR  = 2'b10;
  localparam logic [1:0] MODE_NAND = 2'b11;

  state_t           state, state_next;
  logic [WIDTH-1:0] vec, vec_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             ovf, ovf_next;
  logic [1:0]       mode_q, mode_next;
  logic             beat;
  logic             handoff;

  // Column fold operator; NAND accumulates with AND and inverts only at the output.
  function automatic logic [WIDTH-1:0] fold(input logic [1:0] m,
                                            input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    case (m)
      MODE_OR:  fold = a | b;
      MODE_XOR: fold = a ^ b;
      default:  fold = a & b;
    endcase
  endfunction

  // Handshake: both sides are forced low while reset is asserted.
  assign IN_READY  = ~RST & (state != DONE);
  assign OUT_VALID = ~RST & (state == DONE);
  assign beat      = IN_VALID & IN_READY;
  assign handoff   = OUT_VALID & OUT_READY;

  // State and accumulator registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      vec    <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      mode_q <= MODE_AND;
    end else begin
      state  <= state_next;
      vec    <= vec_next;
      cnt    <= cnt_next;
      ovf    <= ovf_next;
      mode_q <= mode_next;
    end
  end

  // Next-state and accumulator update.
  always_comb begin
    state_next = state;
    vec_next   = vec;
    cnt_next   = cnt;
    ovf_next   = ovf;
    mode_next  = mode_q;
    case (state)
      IDLE: begin
        if (beat) begin
          mode_next  = MODE;
          vec_next   = IN_DATA;
          cnt_next   = CNT_W'(1);
          ovf_next   = 1'b0;
          state_next = IN_LAST ? DONE : ACC;
        end
      end
      ACC: begin
        if (beat) begin
          vec_next = fold(mode_q, vec, IN_DATA);
          // Overflow means a word arrived when the count was already full.
          if (cnt == CNT_W'(MAX_WORDS)) begin
            ovf_next = 1'b1;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
          state_next = IN_LAST ? DONE : ACC;
        end
      end
      DONE: begin
        if (handoff) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Result decode; everything reads zero outside DONE.
  always_comb begin
    OUT_VEC = '0;
    OUT_BIT = 1'b0;
    OUT_CNT = '0;
    OUT_OVF = 1'b0;
    if (state == DONE) begin
      OUT_CNT = cnt;
      OUT_OVF = ovf;
      case (mode_q)
        MODE_AND: begin
          OUT_VEC = vec;
          OUT_BIT = &vec;
        end
        MODE_OR: begin
          OUT_VEC = vec;
          OUT_BIT = |vec;
        end
        MODE_XOR: begin
          OUT_VEC = vec;
          OUT_BIT = ^vec;
        end
        default: begin
          OUT_VEC = ~vec;
          OUT_BIT = ~&vec;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reduce_accum_stream.sv
// tb_reduce_accum_stream: directed, table-driven bench for reduce_accum_stream
// with WIDTH=8, MAX_WORDS=4, plus hand sequences for hold, reset-abort and
// mid-frame MODE changes.
module tb_reduce_accum_stream;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned MAX_WORDS = 4;
  localparam int unsigned CNT_W     = $clog2(MAX_WORDS + 1);

  logic             CLK;
  logic             RST;
  logic [1:0]       MODE;
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] IN_DATA;
  logic             IN_LAST;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] OUT_VEC;
  logic             OUT_BIT;
  logic [CNT_W-1:0] OUT_CNT;
  logic             OUT_OVF;

  int checks;
  int failures;

  reduce_accum_stream #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .MODE     (MODE),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .IN_DATA  (IN_DATA),
    .IN_LAST  (IN_LAST),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .OUT_VEC  (OUT_VEC),
    .OUT_BIT  (OUT_BIT),
    .OUT_CNT  (OUT_CNT),
    .OUT_OVF  (OUT_OVF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  mode;
    int          n;
    logic [63:0] words;   // word i in bits [8*i +: 8]
    logic [7:0]  ev;
    logic        eb;
    logic [2:0]  ec;
    logic        eo;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Sends one frame, checks the held result, then hands it off.
  task automatic run_frame(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    OUT_READY = 1'b1;
    for (int i = 0; i < v.n; i++) begin
      check({tag, "_in_ready"}, 32'(IN_READY), 32'd1);
      IN_VALID = 1'b1;
      MODE     = (i == 0) ? v.mode : ~v.mode;
      IN_DATA  = v.words[8*i +: 8];
      IN_LAST  = (i == v.n - 1);
      tick();
    end
    IN_VALID = 1'b0;
    IN_LAST  = 1'b0;
    IN_DATA  = 8'h00;
    check({tag, "_valid"}, 32'(OUT_VALID), 32'd1);
    check({tag, "_vec"},   32'(OUT_VEC),   32'(v.ev));
    check({tag, "_bit"},   32'(OUT_BIT),   32'(v.eb));
    check({tag, "_cnt"},   32'(OUT_CNT),   32'(v.ec));
    check({tag, "_ovf"},   32'(OUT_OVF),   32'(v.eo));
    tick();
    check({tag, "_idle_valid"}, 32'(OUT_VALID), 32'd0);
    check({tag, "_idle_vec"},   32'(OUT_VEC),   32'd0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    RST       = 1'b1;
    MODE      = 2'b00;
    IN_VALID  = 1'b0;
    IN_DATA   = 8'h00;
    IN_LAST   = 1'b0;
    OUT_READY = 1'b0;

    // mode: 00 AND, 01 OR, 10 XOR, 11 NAND
    tbl[0] = '{mode: 2'b00, n: 3, words: 64'h0000_0000_00E7_FFA5, ev: 8'hA5, eb: 1'b0, ec: 3'd3, eo: 1'b0};
    tbl[1] = '{mode: 2'b10, n: 1, words: 64'h0000_0000_0000_0001, ev: 8'h01, eb: 1'b1, ec: 3'd1, eo: 1'b0};
    tbl[2] = '{mode: 2'b01, n: 6, words: 64'h0000_2010_0804_0201, ev: 8'h3F, eb: 1'b1, ec: 3'd4, eo: 1'b1};
    tbl[3] = '{mode: 2'b11, n: 2, words: 64'h0000_0000_0000_FFFF, ev: 8'h00, eb: 1'b0, ec: 3'd2, eo: 1'b0};
    tbl[4] = '{mode: 2'b10, n: 2, words: 64'h0000_0000_0000_0103, ev: 8'h02, eb: 1'b1, ec: 3'd2, eo: 1'b0};
    tbl[5] = '{mode: 2'b00, n: 1, words: 64'h0000_0000_0000_000F, ev: 8'h0F, eb: 1'b0, ec: 3'd1, eo: 1'b0};
    tbl[6] = '{mode: 2'b10, n: 4, words: 64'h0000_0000_8844_2211, ev: 8'hFF, eb: 1'b0, ec: 3'd4, eo: 1'b0};
    tbl[7] = '{mode: 2'b10, n: 5, words: 64'h0000_0001_8844_2211, ev: 8'hFE, eb: 1'b1, ec: 3'd4, eo: 1'b1};
    tbl[8] = '{mode: 2'b11, n: 2, words: 64'h0000_0000_0000_F00F, ev: 8'hFF, eb: 1'b1, ec: 3'd2, eo: 1'b0};
    tbl[9] = '{mode: 2'b01, n: 1, words: 64'h0000_0000_0000_0000, ev: 8'h00, eb: 1'b0, ec: 3'd1, eo: 1'b0};

    // Reset state: handshakes held low while RST is high.
    tick();
    tick();
    check("rst_in_ready",  32'(IN_READY),  32'd0);
    check("rst_out_valid", 32'(OUT_VALID), 32'd0);
    RST = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(IN_READY), 32'd1);
    check("post_rst_vec",      32'(OUT_VEC),  32'd0);
    check("post_rst_cnt",      32'(OUT_CNT),  32'd0);
    tick();

    for (int k = 0; k < 10; k++) begin
      run_frame(tbl[k], k);
    end

    // NAND frame FF,FF held with OUT_READY low; junk input must be ignored.
    OUT_READY = 1'b0;
    MODE      = 2'b11;
    IN_VALID  = 1'b1;
    IN_DATA   = 8'hFF;
    IN_LAST   = 1'b0;
    tick();
    IN_LAST = 1'b1;
    tick();
    IN_DATA = 8'h00;
    for (int c = 0; c < 5; c++) begin
      MODE = 2'(c);
      check($sformatf("hold%0d_valid", c),    32'(OUT_VALID), 32'd1);
      check($sformatf("hold%0d_vec", c),      32'(OUT_VEC),   32'h00);
      check($sformatf("hold%0d_bit", c),      32'(OUT_BIT),   32'd0);
      check($sformatf("hold%0d_in_ready", c), 32'(IN_READY),  32'd0);
      tick();
    end
    IN_VALID  = 1'b0;
    IN_LAST   = 1'b0;
    OUT_READY = 1'b1;
    tick();
    check("hold_release_valid",    32'(OUT_VALID), 32'd0);
    check("hold_release_in_ready", 32'(IN_READY),  32'd1);

    // Reset after two beats of a partial frame discards it.
    MODE     = 2'b01;
    IN_VALID = 1'b1;
    IN_DATA  = 8'hF0;
    IN_LAST  = 1'b0;
    tick();
    IN_DATA = 8'h0F;
    tick();
    IN_VALID = 1'b0;
    RST      = 1'b1;
    #1;
    check("abort_in_ready_in_rst", 32'(IN_READY), 32'd0);
    tick();
    RST = 1'b0;
    tick();
    check("abort_no_result", 32'(OUT_VALID), 32'd0);
    MODE     = 2'b00;
    IN_VALID = 1'b1;
    IN_DATA  = 8'h0F;
    IN_LAST  = 1'b1;
    tick();
    IN_VALID = 1'b0;
    IN_LAST  = 1'b0;
    check("abort_new_valid", 32'(OUT_VALID), 32'd1);
    check("abort_new_vec",   32'(OUT_VEC),   32'h0F);
    check("abort_new_cnt",   32'(OUT_CNT),   32'd1);
    check("abort_new_ovf",   32'(OUT_OVF),   32'd0);
    tick();

    // MODE toggled every cycle during an XOR frame 03,01 and while DONE.
    MODE     = 2'b10;
    IN_VALID = 1'b1;
    IN_DATA  = 8'h03;
    OUT_READY = 1'b0;
    tick();
    MODE    = 2'b01;
    IN_DATA = 8'h01;
    IN_LAST = 1'b1;
    tick();
    IN_VALID = 1'b0;
    IN_LAST  = 1'b0;
    MODE     = 2'b11;
    #1;
    check("toggle_vec", 32'(OUT_VEC), 32'h02);
    check("toggle_bit", 32'(OUT_BIT), 32'd1);
    tick();
    MODE = 2'b00;
    #1;
    check("toggle_done_vec", 32'(OUT_VEC), 32'h02);
    check("toggle_done_bit", 32'(OUT_BIT), 32'd1);
    OUT_READY = 1'b1;
    tick();
    check("toggle_release_valid", 32'(OUT_VALID), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
